// File: rtl/pulse_timer_if.sv
// pulse_timer_if: control/status bundle for pulse_timer.
//   master (driver side) : ena, start, stop, mode, ticks, width -> ; <- out, busy
//   slave  (timer side)  : ena, start, stop, mode, ticks, width <- ; -> out, busy
//   ena    count enable (low pauses the counter)
//   start  single-cycle launch, samples mode/ticks/width
//   stop   single-cycle halt
//   mode   0 OFF, 1 PERIODIC, 2 PWM, 3 ONESHOT
//   ticks  period in counted cycles (0 is invalid)
//   width  PWM high time in counted cycles
//   out    pulse / PWM output
//   busy   timer running
interface pulse_timer_if #(
  parameter int N = 8
);
  logic         ena;
  logic         start;
  logic         stop;
  logic [1:0]   mode;
  logic [N-1:0] ticks;
  logic [N-1:0] width;
  logic         out;
  logic         busy;

  modport master (
    output ena, start, stop, mode, ticks, width,
    input  out, busy
  );

  modport slave (
    input  ena, start, stop, mode, ticks, width,
    output out, busy
  );
endinterface

// File: rtl/pulse_timer.sv
// pulse_timer: multi-mode pulse / PWM timer (periodic, PWM, one-shot).
//   clk  core clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pulse_timer_if.slave: ena/start/stop/mode/ticks/width in, out/busy out
//
// Period and width are shadowed: a running timer picks up new ticks/width
// only at the wrap edge, so the output never glitches mid-period. The mode
// is fixed for the whole run and only changes on start.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | not running; out = 0, busy = 0
// ST_RUN   | counting 0 .. ticks_q-1 on ena cycles; busy = 1
module pulse_timer #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  pulse_timer_if.slave    bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PWM      = 2'd2,
    MODE_ONESHOT  = 2'd3
  } mode_e;

  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  mode_e        mode_q,  mode_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] ticks_q, ticks_d;
  logic [N-1:0] width_q, width_d;

  logic [N-1:0] ticks_last;
  logic         at_wrap;
  logic         start_ok;
  logic         run_q;
  logic         out_c;

  assign run_q = (state_q == ST_RUN);

  // ticks_q - 1 is only meaningful for a nonzero period; guarding it keeps
  // the compare from matching count_q = all-ones when ticks_q is 0.
  assign ticks_last = (ticks_q != '0) ? (ticks_q - ONE) : '0;
  assign at_wrap    = (ticks_q != '0) && (count_q == ticks_last);
  assign start_ok   = (bus.ticks != '0) && (mode_e'(bus.mode) != MODE_OFF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      count_q <= '0;
      ticks_q <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      ticks_q <= ticks_d;
      width_q <= width_d;
    end
  end

  // Priority: stop, then start, then counting.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    ticks_d = ticks_q;
    width_d = width_q;

    if (bus.stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (bus.start) begin
      count_d = '0;
      if (start_ok) begin
        state_d = ST_RUN;
        mode_d  = mode_e'(bus.mode);
        ticks_d = bus.ticks;
        width_d = bus.width;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (run_q && bus.ena) begin
      if (at_wrap) begin
        count_d = '0;
        ticks_d = bus.ticks;
        width_d = bus.width;
        if ((bus.ticks == '0) || (mode_q == MODE_ONESHOT)) begin
          state_d = ST_IDLE;
        end
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  // Pulse modes qualify with ena so a paused wrap cycle emits nothing;
  // PWM holds its level through a pause.
  always_comb begin
    out_c = 1'b0;
    if (run_q) begin
      case (mode_q)
        MODE_PERIODIC,
        MODE_ONESHOT: out_c = bus.ena & at_wrap;
        MODE_PWM:     out_c = (count_q < width_q);
        default:      out_c = 1'b0;
      endcase
    end
  end

  assign bus.out  = out_c;
  assign bus.busy = run_q;

endmodule

// File: doc/pulse_timer.md
# pulse_timer

Parametrised multi-mode pulse and PWM timer; the next generation of the single-mode periodic pulse generator. It adds periodic, PWM and one-shot modes, explicit start/stop control, and shadowed period/width registers that update glitch-free at period boundaries. It sits beside peripheral drivers (LED/PWM outputs, sample strobes, display refresh) and is clocked in the core clock domain.

## Interface
- N, default 8: width of counter, `ticks` and `width`.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  count enable; low pauses the counter (clock-enable style).
- start  in  1  single-cycle launch; samples `mode`, `ticks`, `width`.
- stop  in  1  single-cycle halt.
- mode  in  2  0 = OFF, 1 = PERIODIC, 2 = PWM, 3 = ONESHOT.
- ticks  in  N  period in cycles (counted `ena` cycles); 0 is invalid.
- width  in  N  PWM high time in counted cycles.
- out  out  1  pulse or PWM output.
- busy  out  1  high while the timer is running.

## Operation
- State registers: `run_q`, `count_q[N-1:0]`, `mode_q`, `ticks_q`, `width_q`.
- Reset (`rst` = 0, asynchronous): `run_q` = 0, `count_q` = 0, `mode_q` = OFF, `ticks_q` = 0, `width_q` = 0. As a result `out` = 0 and `busy` = 0.
- Control priority at each edge: `stop` first, then `start`, then counting.
- `stop`: sets `run_q` = 0 and `count_q` = 0. When `stop` and `start` are asserted together, `stop` wins.
- `start`, when `ticks` ≠ 0 and `mode` ≠ OFF:
  - latches `mode_q`, `ticks_q` and `width_q`;
  - sets `count_q` = 0 and `run_q` = 1;
  - if already busy, the timer restarts from 0.
- `start` with `ticks` = 0 or `mode` = OFF: sets `run_q` = 0 and `count_q` = 0; no pulse is produced.
- Counting: applies when `run_q` = 1, `ena` = 1 and there is no `stop` or `start`.
  - If `count_q` = `ticks_q` − 1, this is a wrap: `count_q` = 0.
  - Otherwise `count_q` = `count_q` + 1.
- At wrap:
  - `ticks_q` and `width_q` reload from the live inputs (shadow update).
  - `mode_q` is not reloaded.
  - If the reloaded `ticks` = 0, `run_q` clears.
  - In ONESHOT, `run_q` clears at wrap.
- `ena` = 0: the counter holds and `run_q` holds.
- `out` is combinational from registered state plus `ena`, and is 0 whenever `run_q` = 0:
  - PERIODIC / ONESHOT: `out` = `ena` and (`count_q` == `ticks_q` − 1). This is one pulse per period, on the cycle that wraps.
  - PWM: `out` = (`count_q` < `width_q`), and is not gated by `ena`, so the level holds while paused.
  - `width_q` = 0 gives constant low.
  - `width_q` ≥ `ticks_q` gives constant high while running.
- `busy` = `run_q`.
- Arithmetic is unsigned N-bit. `count_q` never exceeds `ticks_q` − 1, so there is no overflow wrap. `ticks_q` − 1 is computed only when `ticks_q` ≠ 0.

## Timing
- A start sampled at edge E0 makes `busy` = 1 and `count_q` = 0 in the cycle after E0.
- PERIODIC, with `ena` held high:
  - the first `out` pulse occurs `ticks` cycles after E0, i.e. the cycle with `count_q` = `ticks` − 1;
  - subsequent pulses are every `ticks` cycles;
  - each pulse is exactly 1 cycle wide.
- `ticks` = 1: `out` is high on every cycle with `ena` = 1.
- ONESHOT: exactly one pulse, `ticks` cycles after E0; `busy` falls on the cycle after the pulse.
- PWM: `out` is high for cycles 1..`width` after E0, then low for the remaining `ticks` − `width` cycles of the period, then repeats.
- Shadow updates take effect from the cycle after the wrap edge. Changing `ticks` or `width` mid-period has no effect until the wrap.
- `stop` at edge E: `out` and `busy` are 0 from the cycle after E.
- Reset asserted mid-run: `out` and `busy` fall immediately (asynchronously), without waiting for a clock edge.

## Test plan
- Reset mid-run: N=8, PERIODIC, `ticks`=4, `ena`=1. Drop `rst` between edges → `out`/`busy` go 0 before the next edge; after release, nothing happens until `start`.
- PERIODIC, `ticks`=4, `ena`=1, start at E0 → `out` is high in the cycles after E3, E7 and E11, each exactly 1 cycle; `busy` stays high.
- PERIODIC, `ticks`=4, `ena` low for 3 cycles while `count_q`=2 → the pulse is delayed by 3 cycles and no `out` is asserted during the pause.
- PWM, `ticks`=5, `width`=2 → `out` pattern 1,1,0,0,0 repeating. Change `width` to 4 mid-period → the next period, starting right after the wrap, shows 1,1,1,1,0. Also check `width`=0 → always 0, and `width`=7 → always 1.
- ONESHOT, `ticks`=3 → a single pulse in the cycle after E2, `busy` is 0 from the cycle after E3, and no further pulses occur.
- Control edge cases:
  - `start` and `stop` in the same cycle while busy → stopped.
  - `start` with `ticks`=0 → `busy` stays 0.
  - PERIODIC with `ticks` changed to 0 → stops at the next wrap after that period's pulse.
